// File: rtl/gcd_sched_if.sv
// gcd_sched_if: requester/response bus of the GCD scheduler.
//   req_valid  master->slave  per-requester job valid
//   req_ready  slave->master  one-hot accept (combinational in IDLE)
//   req_a/b    master->slave  packed operands, requester i at [i*W +: W]
//   rsp_valid  slave->master  one-cycle result pulse
//   rsp_id     slave->master  requester index of the result
//   rsp_c      slave->master  gcd result
//   rsp_err    slave->master  job aborted by watchdog
interface gcd_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [W-1:0]      rsp_c;
    logic              rsp_err;

    // Requester / response consumer side
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_err
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_c, rsp_err
    );
endinterface

// File: rtl/gcd_sched.sv
// gcd_sched: round-robin scheduler sharing one GCD core among NREQ requesters.
// One job in flight; FSM IDLE -> ISSUE -> BUSY -> DONE -> IDLE.
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset (also resets the core)
//   bus              gcd_sched_if.slave: req_valid/ready/a/b in, rsp_valid/id/c/err out
//   core_a_o/b_o     operands to core, held from ISSUE through BUSY
//   core_start_o     one-cycle start pulse per job
//   core_finished_i  core done
//   core_c_i         core result
//   core_abort_o     one-cycle core reset pulse on watchdog timeout
// Optional feature: define GCD_SCHED_TIMEOUT_EN to enable the BUSY watchdog
// (TMO_CYC cycles). Without it rsp_err and core_abort_o are tied low.
module gcd_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    gcd_sched_if.slave      bus,
    output logic [W-1:0]    core_a_o,
    output logic [W-1:0]    core_b_o,
    output logic            core_start_o,
    input  logic            core_finished_i,
    input  logic [W-1:0]    core_c_i,
    output logic            core_abort_o
);

    // Elaboration-time parameter sanity
    if (NREQ < 2 || NREQ > 16 || ID_W != $clog2(NREQ) || TMO_CYC == 0) begin : g_bad_cfg
        $error("gcd_sched: inconsistent NREQ/ID_W/TMO_CYC");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] job_id_q;
    logic [W-1:0]    core_a_q;
    logic [W-1:0]    core_b_q;
    logic            core_start_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [W-1:0]    rsp_c_q;

    // Round-robin winner search
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] cand;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    // Walk from the farthest offset down to rr_ptr+1 so the nearest valid
    // requester after the pointer is the last (winning) assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Operand mux for the winner
    always_comb begin
        sel_a = bus.req_a[32'(gnt_idx) * W +: W];
        sel_b = bus.req_b[32'(gnt_idx) * W +: W];
    end

    // One-hot accept, only offered in IDLE
    always_comb begin
        bus.req_ready = '0;
        if (state_q == S_IDLE && gnt_vld) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] wdog_q;
    logic             rsp_err_q;
    logic             core_abort_q;

    // FSM, datapath and watchdog; a finished seen in the timeout cycle wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= ID_W'(NREQ - 1);
            job_id_q     <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_c_q      <= '0;
            rsp_err_q    <= 1'b0;
            core_abort_q <= 1'b0;
            wdog_q       <= '0;
        end else begin
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            core_abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        core_a_q     <= sel_a;
                        core_b_q     <= sel_b;
                        job_id_q     <= gnt_idx;
                        rr_ptr_q     <= gnt_idx;
                        core_start_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    if (core_finished_i) begin
                        rsp_c_q     <= core_c_i;
                        rsp_id_q    <= job_id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (wdog_q == TMO_W'(TMO_CYC - 1)) begin
                        rsp_c_q      <= '0;
                        rsp_id_q     <= job_id_q;
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= 1'b1;
                        core_abort_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_err  = rsp_err_q;
    assign core_abort_o = core_abort_q;
`else
    // FSM and datapath; BUSY waits for the core indefinitely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= ID_W'(NREQ - 1);
            job_id_q     <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_c_q      <= '0;
        end else begin
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        core_a_q     <= sel_a;
                        core_b_q     <= sel_b;
                        job_id_q     <= gnt_idx;
                        rr_ptr_q     <= gnt_idx;
                        core_start_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_BUSY;
                end
                S_BUSY: begin
                    if (core_finished_i) begin
                        rsp_c_q     <= core_c_i;
                        rsp_id_q    <= job_id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_err  = 1'b0;
    assign core_abort_o = 1'b0;
`endif

    assign core_a_o      = core_a_q;
    assign core_b_o      = core_b_q;
    assign core_start_o  = core_start_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: directed self-checking bench for gcd_sched with a behavioural GCD core stub.
module tb_gcd_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned ID_W = 2;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  core_a, core_b, core_c;
    logic          core_start, core_finished, core_abort;

    gcd_sched_if #(.NREQ(NREQ), .W(W), .ID_W(ID_W)) bus ();

    gcd_sched #(.NREQ(NREQ), .W(W), .ID_W(ID_W), .TMO_CYC(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .core_a_o        (core_a),
        .core_b_o        (core_b),
        .core_start_o    (core_start),
        .core_finished_i (core_finished),
        .core_c_i        (core_c),
        .core_abort_o    (core_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stub: result ready core_delay cycles after start; core_hang never finishes
    int   core_delay = 1;
    bit   core_hang  = 1'b0;
    logic stub_busy;
    int   stub_cnt;

    function automatic logic [31:0] gcd_f(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_busy     <= 1'b0;
            stub_cnt      <= 0;
            core_finished <= 1'b0;
            core_c        <= '0;
        end else if (core_abort) begin
            stub_busy     <= 1'b0;
            core_finished <= 1'b0;
        end else if (core_start) begin
            core_c        <= gcd_f(core_a, core_b);
            stub_cnt      <= core_delay;
            stub_busy     <= 1'b1;
            core_finished <= 1'b0;
        end else if (stub_busy && stub_cnt == 0 && !core_hang) begin
            core_finished <= 1'b1;
            stub_busy     <= 1'b0;
        end else if (stub_busy && stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    // Event recorder, sampled on the falling edge
    int q_id[$], q_c[$], q_err[$], q_rcyc[$], q_gnt[$], q_gcyc[$], q_scyc[$];
    int n_start = 0;
    int n_abort = 0;
    int n_onehot_bad = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid) begin
                q_id.push_back(int'(bus.rsp_id));
                q_c.push_back(int'(bus.rsp_c));
                q_err.push_back(int'(bus.rsp_err));
                q_rcyc.push_back(cyc);
            end
            if (core_start) begin
                n_start++;
                q_scyc.push_back(cyc);
            end
            if (core_abort) n_abort++;
            if (!$onehot0(bus.req_ready)) n_onehot_bad++;
            if (|(bus.req_valid & bus.req_ready)) begin
                int g;
                g = 0;
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) g = i;
                end
                q_gnt.push_back(g);
                q_gcyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_id.delete(); q_c.delete(); q_err.delete(); q_rcyc.delete();
        q_gnt.delete(); q_gcyc.delete(); q_scyc.delete();
        n_start = 0;
        n_abort = 0;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        core_hang     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_rsp(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            tick();
            if (q_id.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_gnt(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            tick();
            if (q_gnt.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0) begin n_errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); end
        n_checks++; if (bus.rsp_c !== 32'd0) begin n_errors++; $display("FAIL reset_rsp_c: got %0d want 0", bus.rsp_c); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        n_checks++; if (core_a !== 32'd0 || core_b !== 32'd0) begin n_errors++; $display("FAIL reset_core_ab: got %0d,%0d want 0,0", core_a, core_b); end
        n_checks++; if (core_start !== 1'b0 || core_abort !== 1'b0) begin n_errors++; $display("FAIL reset_core_ctl: got start=%b abort=%b want 0,0", core_start, core_abort); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.rsp_valid !== 1'b0 || core_start !== 1'b0) begin n_errors++; $display("FAIL post_reset_idle: got rsp_valid=%b start=%b want 0,0", bus.rsp_valid, core_start); end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        clear_q();
        core_delay = 2;
        set_op(0, 32'd48, 32'd18);
        bus.req_valid = 4'b0001;
        wait_gnt(1, 20, ok);
        bus.req_valid = '0;
        n_checks++; if (!ok) begin n_errors++; $display("FAIL single_grant: got no grant want grant 0"); end
        wait_rsp(1, 50, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL single_rsp: got no response want 1"); end
        repeat (6) tick();
        n_checks++; if (q_id.size() != 1) begin n_errors++; $display("FAIL single_rsp_count: got %0d want 1", q_id.size()); end
        n_checks++; if (n_start != 1) begin n_errors++; $display("FAIL single_start_cycles: got %0d want 1", n_start); end
        if (q_id.size() >= 1 && q_gcyc.size() >= 1 && q_scyc.size() >= 1) begin
            n_checks++; if (q_id[0] != 0) begin n_errors++; $display("FAIL single_id: got %0d want 0", q_id[0]); end
            n_checks++; if (q_c[0] != 6) begin n_errors++; $display("FAIL single_c: got %0d want 6", q_c[0]); end
            n_checks++; if (q_err[0] != 0) begin n_errors++; $display("FAIL single_err: got %0d want 0", q_err[0]); end
            n_checks++; if (q_scyc[0] - q_gcyc[0] != 1) begin n_errors++; $display("FAIL single_start_lat: got %0d want 1", q_scyc[0] - q_gcyc[0]); end
            n_checks++; if (q_rcyc[0] - q_gcyc[0] != 6) begin n_errors++; $display("FAIL single_rsp_lat: got %0d want 6", q_rcyc[0] - q_gcyc[0]); end
        end
    endtask

    task automatic test_all();
        bit ok;
        int exp_c[4];
        exp_c = '{21, 6, 7, 25};
        do_reset();
        clear_q();
        core_delay = 1;
        set_op(0, 32'd1071, 32'd462);
        set_op(1, 32'd48,   32'd18);
        set_op(2, 32'd35,   32'd14);
        set_op(3, 32'd100,  32'd75);
        n_onehot_bad = 0;
        bus.req_valid = 4'b1111;
        wait_rsp(6, 300, ok);
        bus.req_valid = '0;
        repeat (10) tick();
        n_checks++; if (!ok) begin n_errors++; $display("FAIL all_rsp: got %0d responses want 6", q_id.size()); end
        n_checks++; if (q_gnt.size() != 6) begin n_errors++; $display("FAIL all_grant_count: got %0d want 6", q_gnt.size()); end
        n_checks++; if (n_onehot_bad != 0) begin n_errors++; $display("FAIL all_ready_onehot: got %0d bad cycles want 0", n_onehot_bad); end
        for (int i = 0; i < 6; i++) begin
            if (i < q_gnt.size() && i < q_id.size()) begin
                n_checks++; if (q_gnt[i] != i % 4) begin n_errors++; $display("FAIL all_grant[%0d]: got %0d want %0d", i, q_gnt[i], i % 4); end
                n_checks++; if (q_id[i] != i % 4) begin n_errors++; $display("FAIL all_id[%0d]: got %0d want %0d", i, q_id[i], i % 4); end
                n_checks++; if (q_c[i] != exp_c[i % 4]) begin n_errors++; $display("FAIL all_c[%0d]: got %0d want %0d", i, q_c[i], exp_c[i % 4]); end
            end
        end
        if (q_gcyc.size() >= 2) begin
            n_checks++; if (q_gcyc[1] - q_gcyc[0] != 6) begin n_errors++; $display("FAIL back_to_back_spacing: got %0d want 6", q_gcyc[1] - q_gcyc[0]); end
        end
    endtask

    task automatic test_fair();
        bit ok;
        int exp_g[3];
        int exp_c[3];
        exp_g = '{2, 1, 2};
        exp_c = '{7, 6, 7};
        do_reset();
        clear_q();
        core_delay = 1;
        set_op(1, 32'd48, 32'd18);
        set_op(2, 32'd35, 32'd14);
        bus.req_valid = 4'b0100;
        wait_rsp(1, 50, ok);
        bus.req_valid[1] = 1'b1;
        wait_gnt(2, 50, ok);
        bus.req_valid[1] = 1'b0;
        wait_rsp(3, 100, ok);
        bus.req_valid = '0;
        repeat (10) tick();
        n_checks++; if (q_gnt.size() != 3) begin n_errors++; $display("FAIL fair_grant_count: got %0d want 3", q_gnt.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < q_gnt.size() && i < q_id.size()) begin
                n_checks++; if (q_gnt[i] != exp_g[i]) begin n_errors++; $display("FAIL fair_grant[%0d]: got %0d want %0d", i, q_gnt[i], exp_g[i]); end
                n_checks++; if (q_id[i] != exp_g[i] || q_c[i] != exp_c[i]) begin n_errors++; $display("FAIL fair_rsp[%0d]: got id=%0d c=%0d want id=%0d c=%0d", i, q_id[i], q_c[i], exp_g[i], exp_c[i]); end
            end
        end
    endtask

    task automatic test_hold();
        bit ok;
        do_reset();
        clear_q();
        core_delay = 6;
        set_op(3, 32'd35, 32'd14);
        bus.req_valid = 4'b1000;
        wait_gnt(1, 20, ok);
        bus.req_valid = '0;
        set_op(3, 32'd1000, 32'd999);
        repeat (3) tick();
        n_checks++; if (core_a !== 32'd35 || core_b !== 32'd14) begin n_errors++; $display("FAIL hold_core_ab: got %0d,%0d want 35,14", core_a, core_b); end
        wait_rsp(1, 50, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL hold_rsp: got no response want 1"); end
        if (q_id.size() >= 1) begin
            n_checks++; if (q_id[0] != 3 || q_c[0] != 7) begin n_errors++; $display("FAIL hold_result: got id=%0d c=%0d want id=3 c=7", q_id[0], q_c[0]); end
        end
    endtask

    // Runs straight after test_hold so rsp_id/rsp_c hold non-reset values
    task automatic test_reset_mid();
        bit ok;
        clear_q();
        core_delay = 10;
        set_op(0, 32'd1071, 32'd462);
        bus.req_valid = 4'b0001;
        wait_gnt(1, 20, ok);
        bus.req_valid = '0;
        repeat (4) tick();
        n_checks++; if (bus.rsp_c !== 32'd7 || bus.rsp_id !== 2'd3) begin n_errors++; $display("FAIL mid_hold_last: got id=%0d c=%0d want id=3 c=7", bus.rsp_id, bus.rsp_c); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (core_a !== 32'd0 || core_b !== 32'd0) begin n_errors++; $display("FAIL mid_reset_core_ab: got %0d,%0d want 0,0", core_a, core_b); end
        n_checks++; if (bus.rsp_c !== 32'd0 || bus.rsp_id !== 2'd0 || bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset_rsp: got v=%b id=%0d c=%0d want 0,0,0", bus.rsp_valid, bus.rsp_id, bus.rsp_c); end
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        n_checks++; if (q_id.size() != 0) begin n_errors++; $display("FAIL mid_reset_no_rsp: got %0d responses want 0", q_id.size()); end
        clear_q();
        core_delay = 1;
        set_op(1, 32'd100, 32'd75);
        bus.req_valid = 4'b0010;
        wait_gnt(1, 20, ok);
        bus.req_valid = '0;
        wait_rsp(1, 50, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL mid_after_rsp: got no response want 1"); end
        if (q_id.size() >= 1) begin
            n_checks++; if (q_id[0] != 1 || q_c[0] != 25 || q_err[0] != 0) begin n_errors++; $display("FAIL mid_after_result: got id=%0d c=%0d err=%0d want 1,25,0", q_id[0], q_c[0], q_err[0]); end
        end
    endtask

`ifdef GCD_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        do_reset();
        clear_q();
        core_delay = 0;
        core_hang  = 1'b1;
        set_op(2, 32'd48, 32'd18);
        bus.req_valid = 4'b0100;
        wait_gnt(1, 20, ok);
        bus.req_valid = '0;
        wait_rsp(1, 60, ok);
        core_hang = 1'b0;
        n_checks++; if (!ok) begin n_errors++; $display("FAIL tmo_rsp: got no response want 1"); end
        n_checks++; if (n_abort != 1) begin n_errors++; $display("FAIL tmo_abort: got %0d pulses want 1", n_abort); end
        if (q_id.size() >= 1 && q_gcyc.size() >= 1) begin
            n_checks++; if (q_err[0] != 1 || q_c[0] != 0 || q_id[0] != 2) begin n_errors++; $display("FAIL tmo_result: got err=%0d c=%0d id=%0d want 1,0,2", q_err[0], q_c[0], q_id[0]); end
            n_checks++; if (q_rcyc[0] - q_gcyc[0] != 18) begin n_errors++; $display("FAIL tmo_latency: got %0d want 18", q_rcyc[0] - q_gcyc[0]); end
        end
        clear_q();
        core_delay = 1;
        set_op(0, 32'd100, 32'd75);
        bus.req_valid = 4'b0001;
        wait_gnt(1, 20, ok);
        bus.req_valid = '0;
        wait_rsp(1, 50, ok);
        if (q_id.size() >= 1) begin
            n_checks++; if (q_c[0] != 25 || q_err[0] != 0) begin n_errors++; $display("FAIL tmo_next: got c=%0d err=%0d want 25,0", q_c[0], q_err[0]); end
        end else begin
            n_checks++; n_errors++; $display("FAIL tmo_next: got no response want 1");
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        test_reset();
        test_single();
        test_all();
        test_fair();
        test_hold();
        test_reset_mid();
`ifdef GCD_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion want finish before 200000");
        $fatal(1, "simulation time limit");
    end
endmodule
